// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output-port state encoding and small
// decode helpers used by the switch datapath.
package noc_pkg;

    localparam int FLIT_TYPE_W = 2;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_BODY      = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_HEAD      = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_TAIL      = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_HEAD_TAIL = 2'b11;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    typedef enum logic {
        ST_IDLE   = STATE_IDLE,
        ST_LOCKED = STATE_LOCKED
    } port_state_e;

    // Vectors wider than this are not supported by is_onehot.
    localparam int ONEHOT_MAX_W = 32;

    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic type_is_head(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_TYPE_HEAD) || (t == FLIT_TYPE_HEAD_TAIL);
    endfunction

    function automatic logic type_is_tail(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_TYPE_TAIL) || (t == FLIT_TYPE_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// N-way AND-OR multiplexer with a one-hot select; an all-zero select yields zero.
module onehot_mux #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   y
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // logic, so no path leaves it unassigned and no latch is inferred.
        y = '0;
        for (int i = 0; i < N; i++) begin
            y = y | (data[i*W +: W] & {W{sel[i]}});
        end
    end

endmodule

// File: rtl/switch_output_port.sv
// NoC switch output port: requests arbitration for head flits, locks onto the granted
// input for a whole wormhole packet and streams its flits through a registered output.
module switch_output_port
    import noc_pkg::*;
#(
    parameter int IN_N   = 5,
    parameter int FLIT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [IN_N-1:0]        valid_i,
    input  logic [IN_N*FLIT_W-1:0] flit_i,
    output logic [IN_N-1:0]        rd_en_o,
    output logic [IN_N-1:0]        arb_req_o,
    input  logic [IN_N-1:0]        grant_i,
    output logic [FLIT_W-1:0]      data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int TYPE_LSB = FLIT_W - FLIT_TYPE_W;

    port_state_e           state_q, state_d;
    logic [IN_N-1:0]       sel_q, sel_d;
    logic                  first_q, first_d;
    logic                  err_d;
    logic                  xfer;
    logic [IN_N-1:0]       head_req;
    logic [FLIT_W-1:0]     sel_flit;
    logic [FLIT_TYPE_W-1:0] sel_type;

    always_comb begin
        head_req = '0;
        for (int i = 0; i < IN_N; i++) begin
            head_req[i] = valid_i[i] & type_is_head(flit_i[i*FLIT_W + TYPE_LSB +: FLIT_TYPE_W]);
        end
    end

    // The data path is steered by the latched select only, never by the live grant.
    onehot_mux #(
        .N (IN_N),
        .W (FLIT_W)
    ) u_sel_mux (
        .sel  (sel_q),
        .data (flit_i),
        .y    (sel_flit)
    );

    assign sel_type = sel_flit[TYPE_LSB +: FLIT_TYPE_W];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        first_d = first_q;
        err_d   = 1'b0;
        xfer    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!is_onehot(ONEHOT_MAX_W'(grant_i))) begin
                    err_d = (grant_i != '0);
                end else if ((grant_i & head_req) != '0) begin
                    sel_d   = grant_i;
                    first_d = 1'b1;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                xfer = ((valid_i & sel_q) != '0) && (!valid_o || ready_i);
                if (xfer) begin
                    first_d = 1'b0;
                    err_d   = type_is_head(sel_type) && !first_q;
                    if (type_is_tail(sel_type)) begin
                        sel_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pop strobes and requests are combinational, so they are forced low during reset.
    assign rd_en_o   = (xfer && !rst_i) ? sel_q : '0;
    assign arb_req_o = (state_q == ST_IDLE && !rst_i) ? head_req : '0;
    assign busy_o    = (state_q == ST_LOCKED);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            first_q <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            err_o   <= err_d;
            if (xfer) begin
                data_o  <= sel_flit;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
